// File: rtl/hamming_decoder_7_4.sv
// Hamming(7,4) receive decoder: two-stage valid/ready pipeline (syndrome, then
// correction) with a saturating count of delivered words that needed correction.
module hamming_decoder_7_4 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       code_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       data_out,
  output logic             err_corrected,
  output logic [2:0]       syndrome,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_count
);

  // Syndrome bits are the parity checks over Hamming positions; position k is code bit 7-k.
  function automatic logic [2:0] calc_syndrome(input logic [6:0] c);
    logic s1, s2, s3;
    s1 = c[6] ^ c[4] ^ c[2] ^ c[0];
    s2 = c[5] ^ c[4] ^ c[1] ^ c[0];
    s3 = c[3] ^ c[2] ^ c[1] ^ c[0];
    return {s3, s2, s1};
  endfunction

  function automatic logic [3:0] correct_data(input logic [6:0] c, input logic [2:0] s);
    logic [6:0] fixed;
    logic [2:0] idx;
    fixed = c;
    idx   = 3'd7 - s;
    if (s != 3'd0) fixed[idx] = ~fixed[idx];
    return {fixed[0], fixed[1], fixed[2], fixed[4]};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic             advance;
  logic             vld_p1_q, vld_p1_d;
  logic [6:0]       code_p1_q, code_p1_d;
  logic [2:0]       syn_p1_q, syn_p1_d;
  logic             vld_p2_q, vld_p2_d;
  logic [3:0]       data_p2_q, data_p2_d;
  logic             err_p2_q, err_p2_d;
  logic [2:0]       syn_p2_q, syn_p2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    advance   = !vld_p2_q || out_ready;
    vld_p1_d  = vld_p1_q;
    code_p1_d = code_p1_q;
    syn_p1_d  = syn_p1_q;
    vld_p2_d  = vld_p2_q;
    data_p2_d = data_p2_q;
    err_p2_d  = err_p2_q;
    syn_p2_d  = syn_p2_q;
    if (advance) begin
      // p1: capture codeword and its syndrome
      vld_p1_d  = in_valid;
      code_p1_d = code_in;
      syn_p1_d  = calc_syndrome(code_in);
      // p2: apply correction and extract data
      vld_p2_d  = vld_p1_q;
      data_p2_d = correct_data(code_p1_q, syn_p1_q);
      err_p2_d  = |syn_p1_q;
      syn_p2_d  = syn_p1_q;
    end
    // Clear takes priority over a same-cycle corrected delivery.
    cnt_d = cnt_q;
    if (cnt_clr) cnt_d = '0;
    else if (vld_p2_q && out_ready && err_p2_q) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      err_p2_q  <= 1'b0;
      syn_p2_q  <= '0;
      cnt_q     <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      data_p2_q <= data_p2_d;
      err_p2_q  <= err_p2_d;
      syn_p2_q  <= syn_p2_d;
      cnt_q     <= cnt_d;
    end
  end

  // First-stage payload is qualified by vld_p1_q, so it needs no reset.
  always_ff @(posedge clk) begin
    code_p1_q <= code_p1_d;
    syn_p1_q  <= syn_p1_d;
  end

  assign in_ready      = advance;
  assign out_valid     = vld_p2_q;
  assign data_out      = data_p2_q;
  assign err_corrected = err_p2_q;
  assign syndrome      = syn_p2_q;
  assign corr_count    = cnt_q;

endmodule

// File: tb/tb_hamming_decoder_7_4.sv
// Bench for hamming_decoder_7_4: directed vectors, backpressure streaming and random
// traffic scored against a position-based Hamming model; CNT_W=8 and CNT_W=2 run side by side.
module tb_hamming_decoder_7_4;

  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready, cnt_clr;
  logic [6:0] code_in;
  logic       in_ready, out_valid, err_corrected;
  logic [3:0] data_out;
  logic [2:0] syndrome;
  logic [7:0] corr_count;
  logic       in_ready2, out_valid2, err2;
  logic [3:0] data_out2;
  logic [2:0] syn2;
  logic [1:0] corr_count2;

  always #5 clk = ~clk;

  hamming_decoder_7_4 #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .code_in(code_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .err_corrected(err_corrected), .syndrome(syndrome), .cnt_clr(cnt_clr),
    .corr_count(corr_count));

  hamming_decoder_7_4 #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .code_in(code_in),
    .out_valid(out_valid2), .out_ready(out_ready), .data_out(data_out2),
    .err_corrected(err2), .syndrome(syn2), .cnt_clr(cnt_clr),
    .corr_count(corr_count2));

  typedef struct packed {
    logic [3:0] d;
    logic [2:0] s;
    logic       e;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   m8 = 0;
  int   m2 = 0;
  int   delivered = 0;
  bit   last_in_xfer;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Encoder from Hamming positions: data at 3,5,6,7; parity p covers positions with bit p set.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [7:1] pos;
    logic [6:0] c;
    pos = '0;
    pos[3] = d[0]; pos[5] = d[1]; pos[6] = d[2]; pos[7] = d[3];
    for (int p = 1; p <= 4; p = p * 2)
      for (int k = 1; k <= 7; k++)
        if ((k & p) != 0 && k != p) pos[p] = pos[p] ^ pos[k];
    for (int k = 1; k <= 7; k++) c[7-k] = pos[k];
    return c;
  endfunction

  // Syndrome = XOR of the position numbers of all set bits.
  function automatic logic [2:0] ref_syn(input logic [6:0] c);
    int s = 0;
    for (int k = 1; k <= 7; k++) if (c[7-k]) s = s ^ k;
    return 3'(s);
  endfunction

  function automatic exp_t ref_decode(input logic [6:0] c);
    exp_t r;
    int   s;
    s = int'(ref_syn(c));
    if (s != 0) c[7-s] = ~c[7-s];
    r.d = {c[0], c[1], c[2], c[4]};
    r.s = 3'(s);
    r.e = (s != 0);
    return r;
  endfunction

  // One clock cycle: score the transfers implied by the current inputs, then advance.
  task automatic tick();
    exp_t e;
    bit   oerr;
    #1;
    last_in_xfer = 1'b0;
    if (rst) begin
      expq.delete();
      m8 = 0;
      m2 = 0;
    end else begin
      chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
      oerr = 1'b0;
      if (out_valid && out_ready) begin
        chk("word_expected", {31'd0, (expq.size() != 0)}, 32'd1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("data_out", {28'd0, data_out}, {28'd0, e.d});
          chk("syndrome", {29'd0, syndrome}, {29'd0, e.s});
          chk("err_corrected", {31'd0, err_corrected}, {31'd0, e.e});
          oerr = e.e;
          delivered++;
        end
      end
      if (cnt_clr) begin
        m8 = 0;
        m2 = 0;
      end else if (oerr) begin
        if (m8 < 255) m8++;
        if (m2 < 3) m2++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(ref_decode(code_in));
        last_in_xfer = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    chk("corr_count8", {24'd0, corr_count}, m8);
    chk("corr_count2", {30'd0, corr_count2}, m2);
  endtask

  task automatic directed(input logic [6:0] c, input logic [3:0] d, input logic [2:0] s,
                          input logic e, input int cnt);
    in_valid = 1'b1; code_in = c; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat1_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("lat2_out_valid", {31'd0, out_valid}, 32'd1);
    chk("dir_data", {28'd0, data_out}, {28'd0, d});
    chk("dir_syn", {29'd0, syndrome}, {29'd0, s});
    chk("dir_err", {31'd0, err_corrected}, {31'd0, e});
    tick();
    chk("dir_cnt", {24'd0, corr_count}, cnt);
    chk("dir_drained", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic drain();
    int budget = 0;
    in_valid = 1'b0;
    while ((out_valid || expq.size() != 0) && budget < 200) begin
      out_ready = 1'(($urandom % 4) != 0);
      tick();
      budget++;
    end
    chk("drain_in_time", {31'd0, (budget < 200)}, 32'd1);
    chk("queue_empty", expq.size(), 32'd0);
  endtask

  initial begin
    int   idx, cyc, d0;
    logic [6:0] c;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0; code_in = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {28'd0, data_out}, 32'd0);
    chk("rst_err", {31'd0, err_corrected}, 32'd0);
    chk("rst_syn", {29'd0, syndrome}, 32'd0);
    chk("rst_cnt", {24'd0, corr_count}, 32'd0);
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    directed(7'h55, 4'hB, 3'd0, 1'b0, 0);
    directed(7'h45, 4'hB, 3'd3, 1'b1, 1);
    directed(7'h40, 4'h0, 3'd1, 1'b1, 2);
    directed(7'h41, 4'hC, 3'd6, 1'b1, 3);

    // Stream the 16 clean codewords under random backpressure.
    delivered = 0;
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 400) begin
      in_valid = 1'b1;
      code_in = encode(4'(idx));
      out_ready = 1'($urandom % 2);
      tick();
      if (last_in_xfer) idx++;
      cyc++;
    end
    chk("stream_accepted", idx, 32'd16);
    drain();
    chk("stream_delivered", delivered, 32'd16);

    // Saturation: 5 single-error words.
    cnt_clr = 1'b1; in_valid = 1'b0;
    tick();
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      c = encode(4'($urandom));
      d0 = $urandom_range(0, 6);
      c[d0] = ~c[d0];
      in_valid = 1'b1; code_in = c; out_ready = 1'b1;
      tick();
    end
    drain();
    chk("sat_cnt2", {30'd0, corr_count2}, 32'd3);
    chk("sat_cnt8", {24'd0, corr_count}, 32'd5);

    // Clear coinciding with a corrected-word delivery.
    in_valid = 1'b1; code_in = 7'h45; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    chk("clr_setup_valid", {31'd0, out_valid}, 32'd1);
    cnt_clr = 1'b1; out_ready = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_wins", {24'd0, corr_count}, 32'd0);
    drain();

    // Random traffic with clean, single and double errors.
    for (int i = 0; i < 300; i++) begin
      c = encode(4'($urandom));
      case ($urandom % 3)
        0: ;
        1: begin d0 = $urandom_range(0, 6); c[d0] = ~c[d0]; end
        default: begin
          d0 = $urandom_range(0, 6); c[d0] = ~c[d0];
          d0 = (d0 + $urandom_range(1, 6)) % 7; c[d0] = ~c[d0];
        end
      endcase
      in_valid = 1'($urandom % 4 != 0);
      code_in = c;
      out_ready = 1'($urandom % 3 != 0);
      cnt_clr = 1'($urandom % 50 == 0);
      tick();
    end
    cnt_clr = 1'b0;
    drain();

    // Reset with both stages full.
    in_valid = 1'b1; code_in = 7'h45; out_ready = 1'b0;
    tick();
    tick();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_stall", {31'd0, in_ready}, 32'd0);
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_data", {28'd0, data_out}, 32'd0);
    chk("midrst_err", {31'd0, err_corrected}, 32'd0);
    chk("midrst_syn", {29'd0, syndrome}, 32'd0);
    chk("midrst_cnt", {24'd0, corr_count}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("midrst_no_ghost", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
